// File: rtl/rv_mem_pkg.sv
// Shared load/store path definitions: RV32I load funct3 codes, response
// error codes, load-unit FSM states and request-decode helpers.
package rv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_MISAL = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_ILL   = 2'b11;

    typedef enum logic [1:0] {LU_IDLE, LU_MEM, LU_RESP} lu_state_e;

    // Captured request context, all that extraction needs after accept
    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] off;
    } ld_ctx_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == F3_LH || f3 == F3_LHU) && off[0]) || (f3 == F3_LW && off != 2'b00);
    endfunction

endpackage

// File: rtl/load_unit_if.sv
// Load request, data-memory read and response handshakes of the load unit.
interface load_unit_if #(parameter int ADDR_W = 32);
    logic              ld_valid;
    logic              ld_ready;
    logic [2:0]        ld_funct3;
    logic [ADDR_W-1:0] ld_addr;
    logic [4:0]        ld_rd;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [4:0]        rsp_rd;
    logic [1:0]        rsp_err;

    modport slave (
        input  ld_valid, ld_funct3, ld_addr, ld_rd, mem_ack, mem_rdata, rsp_ready,
        output ld_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_err
    );

    modport master (
        output ld_valid, ld_funct3, ld_addr, ld_rd, mem_ack, mem_rdata, rsp_ready,
        input  ld_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_err
    );
endinterface

// File: rtl/load_extract.sv
// Combinational byte/half lane select with sign or zero extension
// (little-endian lanes) of a returned memory word.
module load_extract
    import rv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] result
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = 8'(word >> {off, 3'b000});
    assign lane_h = 16'(word >> {off[1], 4'b0000});

    always_comb begin
        case (funct3)
            F3_LB:   result = {{24{lane_b[7]}}, lane_b};
            F3_LBU:  result = {24'h0, lane_b};
            F3_LH:   result = {{16{lane_h[15]}}, lane_h};
            F3_LHU:  result = {16'h0, lane_h};
            default: result = word;
        endcase
    end
endmodule

// File: rtl/load_unit.sv
// RV32I load unit: one outstanding word read to data memory, lane
// extraction, and a held response carrying rd tag and error code.
module load_unit
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    load_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lu_state_e         state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    ld_ctx_t           ctx, ctx_nx;
    logic              req_q, req_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic              vld_q, vld_nx;
    logic [31:0]       data_q, data_nx;
    logic [4:0]        rd_q, rd_nx;
    logic [1:0]        err_q, err_nx;
    logic [31:0]       ext;

    load_extract u_extract (
        .funct3 (ctx.funct3),
        .off    (ctx.off),
        .word   (bus.mem_rdata),
        .result (ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LU_IDLE;
            cnt    <= '0;
            ctx    <= '0;
            req_q  <= 1'b0;
            addr_q <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
            rd_q   <= '0;
            err_q  <= ERR_OK;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            ctx    <= ctx_nx;
            req_q  <= req_nx;
            addr_q <= addr_nx;
            vld_q  <= vld_nx;
            data_q <= data_nx;
            rd_q   <= rd_nx;
            err_q  <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ctx_nx   = ctx;
        req_nx   = req_q;
        addr_nx  = addr_q;
        vld_nx   = vld_q;
        data_nx  = data_q;
        rd_nx    = rd_q;
        err_nx   = err_q;
        case (state)
            LU_IDLE: if (bus.ld_valid) begin
                ctx_nx  = '{funct3: bus.ld_funct3, off: bus.ld_addr[1:0]};
                rd_nx   = bus.ld_rd;
                data_nx = '0;
                cnt_nx  = '0;
                // Illegal funct3 is checked first so it masks misalignment
                if (!f3_legal(bus.ld_funct3)) begin
                    err_nx   = ERR_ILL;
                    vld_nx   = 1'b1;
                    state_nx = LU_RESP;
                end else if (misaligned(bus.ld_funct3, bus.ld_addr[1:0])) begin
                    err_nx   = ERR_MISAL;
                    vld_nx   = 1'b1;
                    state_nx = LU_RESP;
                end else begin
                    addr_nx  = {bus.ld_addr[ADDR_W-1:2], 2'b00};
                    req_nx   = 1'b1;
                    state_nx = LU_MEM;
                end
            end
            LU_MEM: begin
                // Ack has priority over a timeout expiring in the same cycle
                if (bus.mem_ack) begin
                    req_nx   = 1'b0;
                    data_nx  = ext;
                    err_nx   = ERR_OK;
                    vld_nx   = 1'b1;
                    state_nx = LU_RESP;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    req_nx   = 1'b0;
                    data_nx  = '0;
                    err_nx   = ERR_TMO;
                    vld_nx   = 1'b1;
                    state_nx = LU_RESP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            LU_RESP: if (bus.rsp_ready) begin
                vld_nx   = 1'b0;
                state_nx = LU_IDLE;
            end
            default: state_nx = LU_IDLE;
        endcase
    end

    assign bus.ld_ready  = (state == LU_IDLE);
    assign bus.mem_req   = req_q;
    assign bus.mem_addr  = addr_q;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_rd    = rd_q;
    assign bus.rsp_err   = err_q;
endmodule
